// File: rtl/trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_pkg
// Description : Shared types and default sizes for the trigger capture buffer,
//               the ADC front end and the display readout.
//               - cap_state_t : acquisition state encoding
//               - edge_t      : trigger edge selection
//               - c_DEF_*     : default sample width / window geometry
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_pkg;

    localparam int c_DEF_DATA_W = 12;
    localparam int c_DEF_DEPTH  = 512;
    localparam int c_DEF_PRE    = 128;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRE_FILL  = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_t;

    typedef enum logic [0:0] {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_t;

endpackage : trigger_pkg
`default_nettype wire

// File: rtl/sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : sample_ram
// Description : Simple dual-port sample RAM, DEPTH x DATA_W, one write port and
//               one registered read port on the same clock (BRAM style).
// Ports       : clk, rst      - clock, sync active-high reset (read reg only)
//               i_we/i_waddr/i_wdata - write port
//               i_raddr       - read address
//               o_rdata       - read data, one cycle after i_raddr
// Revision    : 1.0 - initial release
// ============================================================================
module sample_ram #(
    parameter  int DATA_W = 12,
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Output register reset maps onto the BRAM output-latch reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sample_ram
`default_nettype wire

// File: rtl/trigger_capture_buf.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture_buf
// Description : Circular-RAM snapshot buffer with level-crossing trigger.
//               Records PRE pre-trigger and DEPTH-PRE post-trigger samples
//               (trigger sample = first post sample) and freezes the window.
// Ports       : clk, rst            - clock, sync active-high reset
//               sample_in/valid     - ADC sample stream
//               arm                 - start acquisition (IDLE/DONE only)
//               level, edge_sel     - threshold, 0 rising / 1 falling
//               ready, capture_done - status (IDLE|DONE, DONE)
//               triggered, auto_trig- trigger flags
//               rd_addr / rd_data   - trigger-relative readout, 1 cycle latency
// Config      : TRIGGER_AUTO_EN - when defined, force a trigger after
//               AUTO_TIMEOUT valid samples spent waiting for a crossing.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture_buf
    import trigger_pkg::*;
#(
    parameter  int DATA_W       = c_DEF_DATA_W,
    parameter  int DEPTH        = c_DEF_DEPTH,
    parameter  int PRE          = c_DEF_PRE,
    parameter  int AUTO_TIMEOUT = 4096,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic [DATA_W-1:0] level,
    input  logic              edge_sel,
    output logic              ready,
    output logic              capture_done,
    output logic              triggered,
    output logic              auto_trig,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] c_PRE_A     = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0] c_PRE_LAST  = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] c_POST_LAST = ADDR_W'(DEPTH - PRE - 1);

    // Elaboration-time parameter sanity checks.
    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("DEPTH must be a power of two and at least 4");
        end
        if ((PRE < 1) || (PRE > DEPTH - 1)) begin : g_bad_pre
            $error("PRE must lie in 1..DEPTH-1");
        end
        if (AUTO_TIMEOUT < 1) begin : g_bad_timeout
            $error("AUTO_TIMEOUT must be at least 1");
        end
    endgenerate

    cap_state_t        r_state;
    cap_state_t        w_next_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_trig_ptr;
    logic [DATA_W-1:0] r_prev;
    logic              r_triggered;
    logic              r_auto_trig;
    logic              w_we;
    logic              w_arm_ok;
    logic              w_real_trig;
    logic              w_force_trig;
    logic              w_trig;
    logic              w_pre_last;
    logic              w_post_last;
    logic [ADDR_W-1:0] w_raddr;

    function automatic logic f_crossed(input edge_t e,
                                       input logic [DATA_W-1:0] p,
                                       input logic [DATA_W-1:0] c,
                                       input logic [DATA_W-1:0] l);
        if (e == EDGE_RISE) begin
            return (p < l) && (c >= l);
        end
        return (p > l) && (c <= l);
    endfunction

    assign w_arm_ok    = arm && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_real_trig = sample_valid && (r_state == ST_WAIT_TRIG) &&
                         f_crossed(edge_t'(edge_sel), r_prev, sample_in, level);
    assign w_trig      = w_real_trig || w_force_trig;
    assign w_pre_last  = sample_valid && (r_state == ST_PRE_FILL) && (r_cnt == c_PRE_LAST);
    assign w_post_last = sample_valid && (r_state == ST_POST) && (r_cnt == c_POST_LAST);

`ifdef TRIGGER_AUTO_EN
    localparam int                    c_AUTO_W    = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [c_AUTO_W-1:0]   c_AUTO_LAST = c_AUTO_W'(AUTO_TIMEOUT - 1);

    logic [c_AUTO_W-1:0] r_auto_cnt;

    // Counts valid samples spent in WAIT_TRIG; held at zero elsewhere so
    // every entry to WAIT_TRIG starts a fresh timeout.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_WAIT_TRIG)) begin
            r_auto_cnt <= '0;
        end else if (sample_valid) begin
            r_auto_cnt <= r_auto_cnt + 1'b1;
        end
    end

    assign w_force_trig = sample_valid && (r_state == ST_WAIT_TRIG) &&
                          (r_auto_cnt == c_AUTO_LAST);
`else
    assign w_force_trig = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (w_arm_ok)    w_next_state = ST_PRE_FILL;
            ST_PRE_FILL:  if (w_pre_last)  w_next_state = ST_WAIT_TRIG;
            // With a one-sample post window the trigger sample completes it.
            ST_WAIT_TRIG: if (w_trig)      w_next_state = (c_POST_LAST == '0) ? ST_DONE : ST_POST;
            ST_POST:      if (w_post_last) w_next_state = ST_DONE;
            ST_DONE:      if (w_arm_ok)    w_next_state = ST_PRE_FILL;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready        = 1'b0;
        capture_done = 1'b0;
        w_we         = 1'b0;
        case (r_state)
            ST_IDLE:      ready = 1'b1;
            ST_PRE_FILL,
            ST_WAIT_TRIG,
            ST_POST:      w_we  = sample_valid;
            ST_DONE: begin
                ready        = 1'b1;
                capture_done = 1'b1;
            end
            default:      ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pointers, window counter, previous sample, flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
            r_trig_ptr  <= '0;
            r_prev      <= '0;
            r_triggered <= 1'b0;
            r_auto_trig <= 1'b0;
        end else begin
            if (sample_valid) begin
                r_prev <= sample_in;
            end
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            // r_cnt counts PRE_FILL samples, then POST samples; the trigger
            // sample is post sample number one.
            case (r_state)
                ST_PRE_FILL:  if (sample_valid) r_cnt <= w_pre_last ? '0 : r_cnt + 1'b1;
                ST_WAIT_TRIG: if (w_trig)       r_cnt <= ADDR_W'(1);
                ST_POST:      if (sample_valid) r_cnt <= r_cnt + 1'b1;
                default:                        r_cnt <= '0;
            endcase

            if (w_trig) begin
                r_trig_ptr  <= r_wr_ptr;
                r_triggered <= 1'b1;
                r_auto_trig <= w_force_trig && !w_real_trig;
            end

            if (w_arm_ok) begin
                r_wr_ptr    <= '0;
                r_cnt       <= '0;
                r_triggered <= 1'b0;
                r_auto_trig <= 1'b0;
            end
        end
    end

    assign triggered = r_triggered;
    assign auto_trig = r_auto_trig;

    // Window start is PRE slots behind the trigger; ADDR_W arithmetic wraps.
    assign w_raddr = r_trig_ptr - c_PRE_A + rd_addr;

    sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (sample_in),
        .i_raddr (w_raddr),
        .o_rdata (rd_data)
    );

endmodule : trigger_capture_buf
`default_nettype wire
